// File: rtl/regfile_wb_if.sv
// Write-back bus between the ALU/load requesters, decode hazard check and the register-file write port.
// The slave modport is the arbiter side; the master modport is the requester/decode side.
interface regfile_wb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              alu_req;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic [ADDR_W-1:0] rdReg_addr1;
   logic [ADDR_W-1:0] rdReg_addr2;
   logic              sig_regWrite;
   logic [ADDR_W-1:0] wrReg_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_hazard;
   logic              busy;

   modport master (
      output alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data, rdReg_addr1, rdReg_addr2,
      input  alu_ready, mem_ready, sig_regWrite, wrReg_addr, wr_data, rd_hazard, busy
   );

   modport slave (
      input  alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data, rdReg_addr1, rdReg_addr2,
      output alu_ready, mem_ready, sig_regWrite, wrReg_addr, wr_data, rd_hazard, busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two write-back FIFOs (ALU, MEM) drained one entry per cycle into a registered register-file write port.
// Define WB_RR_EN for round-robin arbitration; otherwise MEM has fixed priority over ALU.
module regfile_wb_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   regfile_wb_if.slave  wb
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ALU   = 0;
   localparam int MEM   = 1;

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t            r_state, w_state_next;
   logic [1:0]        w_req, w_push, w_pop, w_nonempty, w_full, w_fifo_hazard;
   logic [ADDR_W-1:0] w_in_addr   [2];
   logic [DATA_W-1:0] w_in_data   [2];
   logic [ADDR_W-1:0] w_head_addr [2];
   logic [DATA_W-1:0] w_head_data [2];
   logic              w_grant_mem;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              w_out_hazard;

   assign w_req           = {wb.mem_req, wb.alu_req};
   assign w_in_addr[ALU]  = wb.alu_addr;
   assign w_in_addr[MEM]  = wb.mem_addr;
   assign w_in_data[ALU]  = wb.alu_data;
   assign w_in_data[MEM]  = wb.mem_data;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [ADDR_W-1:0] r_addr_mem [FIFO_DEPTH];
         logic [DATA_W-1:0] r_data_mem [FIFO_DEPTH];
         logic [PTR_W-1:0]  r_wptr, r_rptr;
         logic [CNT_W-1:0]  r_count;
         logic [PTR_W-1:0]  w_off;
         logic              w_hz;

         assign w_full[gi]      = (r_count == CNT_W'(FIFO_DEPTH));
         assign w_nonempty[gi]  = (r_count != '0);
         assign w_push[gi]      = w_req[gi] && !w_full[gi];
         assign w_head_addr[gi] = r_addr_mem[r_rptr];
         assign w_head_data[gi] = r_data_mem[r_rptr];
         assign w_fifo_hazard[gi] = w_hz;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_wptr  <= '0;
               r_rptr  <= '0;
               r_count <= '0;
            end else begin
               if (w_push[gi]) r_wptr <= r_wptr + PTR_W'(1);
               if (w_pop[gi])  r_rptr <= r_rptr + PTR_W'(1);
               case ({w_push[gi], w_pop[gi]})
                  2'b10:   r_count <= r_count + CNT_W'(1);
                  2'b01:   r_count <= r_count - CNT_W'(1);
                  default: r_count <= r_count;
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (w_push[gi]) begin
               r_addr_mem[r_wptr] <= w_in_addr[gi];
               r_data_mem[r_wptr] <= w_in_data[gi];
            end
         end

         // A slot holds a live entry when its distance from the read pointer is below the count.
         always_comb begin
            w_hz  = 1'b0;
            w_off = '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
               w_off = PTR_W'(j) - r_rptr;
               if ((CNT_W'(w_off) < r_count) &&
                   ((r_addr_mem[j] == wb.rdReg_addr1) || (r_addr_mem[j] == wb.rdReg_addr2)))
                  w_hz = 1'b1;
            end
         end
      end
   endgenerate

`ifdef WB_RR_EN
   logic r_last_mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              r_last_mem <= 1'b1;
      else if (|w_nonempty) r_last_mem <= w_grant_mem;
   end
`endif

   always_comb begin
      w_state_next = S_IDLE;
      w_grant_mem  = 1'b0;
      w_pop        = '0;
      if (|w_nonempty) begin
         w_state_next = S_WRITE;
`ifdef WB_RR_EN
         if (&w_nonempty) w_grant_mem = !r_last_mem;
         else             w_grant_mem = w_nonempty[MEM];
`else
         w_grant_mem = w_nonempty[MEM];
`endif
         w_pop[MEM] = w_grant_mem;
         w_pop[ALU] = !w_grant_mem;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (|w_nonempty) begin
            r_wr_addr <= w_grant_mem ? w_head_addr[MEM] : w_head_addr[ALU];
            r_wr_data <= w_grant_mem ? w_head_data[MEM] : w_head_data[ALU];
         end
      end
   end

   assign w_out_hazard    = (r_state == S_WRITE) &&
                            ((r_wr_addr == wb.rdReg_addr1) || (r_wr_addr == wb.rdReg_addr2));
   assign wb.alu_ready    = !w_full[ALU];
   assign wb.mem_ready    = !w_full[MEM];
   assign wb.sig_regWrite = (r_state == S_WRITE);
   assign wb.wrReg_addr   = r_wr_addr;
   assign wb.wr_data      = r_wr_data;
   assign wb.rd_hazard    = (|w_fifo_hazard) || w_out_hazard;
   assign wb.busy         = (|w_nonempty) || (r_state == S_WRITE);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
// Build with or without WB_RR_EN; the model follows the same macro.
module tb_regfile_wb_arbiter;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

   regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one queue of {addr,data} per requester plus the write-port register.
   logic [ADDR_W+DATA_W-1:0] q_alu [$];
   logic [ADDR_W+DATA_W-1:0] q_mem [$];
   logic              m_sig;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic              m_last_mem;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_alu.delete();
      q_mem.delete();
      m_sig      = 1'b0;
      m_addr     = '0;
      m_data     = '0;
      m_last_mem = 1'b1;
   endtask

   function automatic logic model_hazard();
      logic hz = 1'b0;
      foreach (q_alu[k])
         if (q_alu[k][ADDR_W+DATA_W-1:DATA_W] == wb.rdReg_addr1 ||
             q_alu[k][ADDR_W+DATA_W-1:DATA_W] == wb.rdReg_addr2) hz = 1'b1;
      foreach (q_mem[k])
         if (q_mem[k][ADDR_W+DATA_W-1:DATA_W] == wb.rdReg_addr1 ||
             q_mem[k][ADDR_W+DATA_W-1:DATA_W] == wb.rdReg_addr2) hz = 1'b1;
      if (m_sig && (m_addr == wb.rdReg_addr1 || m_addr == wb.rdReg_addr2)) hz = 1'b1;
      return hz;
   endfunction

   task automatic set_alu(input logic req, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wb.alu_req  = req;
      wb.alu_addr = a;
      wb.alu_data = d;
   endtask

   task automatic set_mem(input logic req, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wb.mem_req  = req;
      wb.mem_addr = a;
      wb.mem_data = d;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model across the edge.
   task automatic step();
      logic do_pop, grant_mem, push_alu, push_mem;
      logic [ADDR_W+DATA_W-1:0] ent;
      @(negedge clk);
      check_val("alu_ready", wb.alu_ready, q_alu.size() < DEPTH);
      check_val("mem_ready", wb.mem_ready, q_mem.size() < DEPTH);
      check_val("sig_regWrite", wb.sig_regWrite, m_sig);
      check_val("rd_hazard", wb.rd_hazard, model_hazard());
      check_val("busy", wb.busy, (q_alu.size() > 0) || (q_mem.size() > 0) || m_sig);
      if (m_sig) begin
         check_val("wrReg_addr", wb.wrReg_addr, m_addr);
         check_val("wr_data", wb.wr_data, m_data);
      end
      push_alu = wb.alu_req && (q_alu.size() < DEPTH);
      push_mem = wb.mem_req && (q_mem.size() < DEPTH);
      do_pop   = (q_alu.size() > 0) || (q_mem.size() > 0);
`ifdef WB_RR_EN
      if (q_alu.size() > 0 && q_mem.size() > 0) grant_mem = !m_last_mem;
      else                                      grant_mem = (q_mem.size() > 0);
`else
      grant_mem = (q_mem.size() > 0);
`endif
      ent = {wb.alu_addr, wb.alu_data};
      if (push_mem) ent = ent; // keep ALU entry; MEM entry built below
      @(posedge clk);
      if (do_pop) begin
         logic [ADDR_W+DATA_W-1:0] w;
         if (grant_mem) w = q_mem.pop_front();
         else           w = q_alu.pop_front();
         m_addr     = w[ADDR_W+DATA_W-1:DATA_W];
         m_data     = w[DATA_W-1:0];
         m_last_mem = grant_mem;
      end
      m_sig = do_pop;
      if (push_alu) q_alu.push_back(ent);
      if (push_mem) q_mem.push_back({wb.mem_addr, wb.mem_data});
      #1;
   endtask

   task automatic idle_cycles(input int n);
      set_alu(1'b0, '0, '0);
      set_mem(1'b0, '0, '0);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      set_alu(1'b0, '0, '0);
      set_mem(1'b0, '0, '0);
      wb.rdReg_addr1 = '0;
      wb.rdReg_addr2 = '0;
      model_reset();
      #1;
      check_val("rst_sig", wb.sig_regWrite, 1'b0);
      check_val("rst_addr", wb.wrReg_addr, 0);
      check_val("rst_data", wb.wr_data, 0);
      check_val("rst_alu_ready", wb.alu_ready, 1'b1);
      check_val("rst_mem_ready", wb.mem_ready, 1'b1);
      check_val("rst_busy", wb.busy, 1'b0);
      check_val("rst_hazard", wb.rd_hazard, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single ALU push r3=0x00AA.
      wb.rdReg_addr1 = 3'd6;
      wb.rdReg_addr2 = 3'd7;
      set_alu(1'b1, 3'd3, 16'h00AA);
      step();
      idle_cycles(3);

      // Simultaneous ALU r1 / MEM r2.
      set_alu(1'b1, 3'd1, 16'h0011);
      set_mem(1'b1, 3'd2, 16'h0022);
      step();
      idle_cycles(4);

      // Three ALU pushes back-to-back.
      for (int i = 0; i < 3; i++) begin
         set_alu(1'b1, 3'(i + 4), 16'(16'h0100 + i));
         step();
      end
      idle_cycles(4);

      // Hazard on MEM r5 with read address 5, then 4.
      wb.rdReg_addr1 = 3'd5;
      set_mem(1'b1, 3'd5, 16'h1234);
      step();
      idle_cycles(4);
      wb.rdReg_addr1 = 3'd4;
      set_mem(1'b1, 3'd5, 16'h1234);
      step();
      idle_cycles(4);

      // Continuous MEM stream plus one ALU push.
      for (int i = 0; i < 8; i++) begin
         set_mem(1'b1, 3'(i), 16'(16'h2000 + i));
         if (i == 1) set_alu(1'b1, 3'd7, 16'hBEEF);
         else        set_alu(1'b0, '0, '0);
         step();
      end
      idle_cycles(5);

      // Fill both FIFOs, then reset mid-drain.
      wb.rdReg_addr1 = 3'd2;
      for (int i = 0; i < 3; i++) begin
         set_alu(1'b1, 3'd2, 16'(16'h3000 + i));
         set_mem(1'b1, 3'd2, 16'(16'h4000 + i));
         step();
      end
      set_alu(1'b0, '0, '0);
      set_mem(1'b0, '0, '0);
      rst = 1'b1;
      model_reset();
      #1;
      check_val("midrst_sig", wb.sig_regWrite, 1'b0);
      check_val("midrst_alu_ready", wb.alu_ready, 1'b1);
      check_val("midrst_mem_ready", wb.mem_ready, 1'b1);
      check_val("midrst_busy", wb.busy, 1'b0);
      check_val("midrst_hazard", wb.rd_hazard, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycles(4);

      // Randomized traffic with varying request density.
      for (int i = 0; i < 600; i++) begin
         int unsigned dens;
         dens = (i < 200) ? 3 : ((i < 400) ? 1 : 6);
         set_alu($urandom_range(0, dens) != 0, 3'($urandom), 16'($urandom));
         set_mem($urandom_range(0, dens) == 0, 3'($urandom), 16'($urandom));
         wb.rdReg_addr1 = 3'($urandom);
         wb.rdReg_addr2 = 3'($urandom);
         step();
      end
      idle_cycles(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
